hazard_fwd_unit: RTL and testbench

Hazard and forwarding controller for the 5-stage pipelined RV32I core. It drives the two 2-bit `select` inputs of the EX-stage `mux_4_1` operand-forwarding muxes, for operands A and B. It also drives the pipeline stall and flush controls. It keeps its own shadow pipeline of register-use metadata through EX, MEM and WB, so the main pipeline registers carry no forwarding fields.

---
 rtl/hazard_fwd_unit.sv | 116 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline: EX operand-forward selects,
// load-use stall, branch flush and saturating event counters, driven by a private shadow pipeline.
module hazard_fwd_unit #(
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic                 id_is_jump,
  input  logic                 ex_pc_src,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic                 reg_write;
    logic                 is_load;
    logic                 is_jump;
  } shadow_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  shadow_t ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic lwstall;

  // Source-register fields of MEM/WB are carried for completeness but never compared.
  logic unused_shadow;
  assign unused_shadow = ^{mem_q.rs1, mem_q.rs2, wb_q.rs1, wb_q.rs2, wb_q.is_load, wb_q.is_jump};

  function automatic logic [1:0] fwd_sel(
    input logic [RF_ADDR_W-1:0] src,
    input shadow_t              mem_e,
    input shadow_t              wb_e
  );
    logic mem_hit, wb_hit;
    mem_hit = mem_e.reg_write && (mem_e.rd != '0) && (mem_e.rd == src);
    wb_hit  = wb_e.reg_write && (wb_e.rd != '0) && (wb_e.rd == src);
    if (src == '0)                       fwd_sel = 2'b00;
    else if (mem_hit && mem_e.is_jump)   fwd_sel = 2'b11;
    else if (mem_hit && !mem_e.is_load)  fwd_sel = 2'b10;
    else if (wb_hit)                     fwd_sel = 2'b01;
    else                                 fwd_sel = 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign forward_b_e = fwd_sel(ex_q.rs2, mem_q, wb_q);

  always_comb begin
    lwstall = ex_q.is_load && (ex_q.rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_q.rd)));
  end

  // A taken branch overrides a load-use stall; the bubble in EX covers both cases.
  assign stall_f = lwstall && !ex_pc_src;
  assign stall_d = lwstall && !ex_pc_src;
  assign flush_d = ex_pc_src;
  assign flush_e = lwstall || ex_pc_src;

  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.rs1       = id_uses_rs1 ? id_rs1 : '0;
      ex_d.rs2       = id_uses_rs2 ? id_rs2 : '0;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_is_load;
      ex_d.is_jump   = id_is_jump;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_d && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus random traffic,
// compared against an instruction-history reference model; a CNT_W=4 twin covers saturation.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0, id_is_load = 0, id_is_jump = 0;
  logic ex_pc_src = 0;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        sf, sd, fd, fe, sf4, sd4, fd4, fe4;
  logic [31:0] sc, fc;
  logic [3:0]  sc4, fc4;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.RF_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_jump(id_is_jump),
    .ex_pc_src(ex_pc_src),
    .forward_a_e(fa), .forward_b_e(fb), .stall_f(sf), .stall_d(sd), .flush_d(fd), .flush_e(fe),
    .stall_count(sc), .flush_count(fc)
  );

  hazard_fwd_unit #(.RF_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_jump(id_is_jump),
    .ex_pc_src(ex_pc_src),
    .forward_a_e(fa4), .forward_b_e(fb4), .stall_f(sf4), .stall_d(sd4), .flush_d(fd4), .flush_e(fe4),
    .stall_count(sc4), .flush_count(fc4)
  );

  typedef struct {
    int rs1; int rs2; int rd;
    bit rw; bit ld; bit jp;
  } instr_t;

  // hist[0] is the instruction now in EX, hist[1] the one ahead of it, hist[2] the oldest.
  instr_t hist[$];
  instr_t id_ins;
  int  total = 0, bad = 0;
  longint m_sc, m_fc, m_sc4, m_fc4;
  bit  m_sd, m_fd, m_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 0; b.ld = 0; b.jp = 0;
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(bubble());
    m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
  endtask

  // Newest older writer of src decides; a load one stage ahead cannot supply data yet.
  function automatic logic [1:0] exp_fwd(input int src);
    if (src == 0) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (hist[age].rw && hist[age].rd == src) begin
        if (age == 1) begin
          if (hist[age].jp) return 2'b11;
          if (!hist[age].ld) return 2'b10;
        end else begin
          return 2'b01;
        end
      end
    end
    return 2'b00;
  endfunction

  task automatic drive(input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit jp, input bit pc);
    bit lw;
    id_rs1 = 5'(r1); id_uses_rs1 = u1; id_rs2 = 5'(r2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_is_load = ld; id_is_jump = jp; ex_pc_src = pc;
    id_ins.rs1 = u1 ? r1 : 0; id_ins.rs2 = u2 ? r2 : 0; id_ins.rd = rd;
    id_ins.rw = rw; id_ins.ld = ld; id_ins.jp = jp;
    #1;
    lw = hist[0].ld && hist[0].rd != 0 &&
         ((u1 && r1 == hist[0].rd) || (u2 && r2 == hist[0].rd));
    m_sd = lw && !pc;
    m_fd = pc;
    m_fe = lw || pc;
    chk("fwd_a", 32'(fa), 32'(exp_fwd(hist[0].rs1)));
    chk("fwd_b", 32'(fb), 32'(exp_fwd(hist[0].rs2)));
    chk("stall_f", 32'(sf), 32'(m_sd));
    chk("stall_d", 32'(sd), 32'(m_sd));
    chk("flush_d", 32'(fd), 32'(m_fd));
    chk("flush_e", 32'(fe), 32'(m_fe));
    chk("stall_count", sc, 32'(m_sc));
    chk("flush_count", fc, 32'(m_fc));
    chk("stall_count4", 32'(sc4), 32'(m_sc4));
    chk("flush_count4", 32'(fc4), 32'(m_fc4));
  endtask

  task automatic tick();
    @(posedge clk);
    hist.push_front(m_fe ? bubble() : id_ins);
    void'(hist.pop_back());
    if (m_sd) begin m_sc++; if (m_sc4 < 15) m_sc4++; end
    if (m_fd) begin m_fc++; if (m_fc4 < 15) m_fc4++; end
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ins(input int r1, input int r2, input int rd);
    drive(r1, 1, r2, 1, rd, 1, 0, 0, 0);
  endtask

  longint sc_before;

  initial begin
    model_reset();
    #2;
    chk("rst_fwd_a", 32'(fa), 0);
    chk("rst_stall", 32'(sd), 0);
    chk("rst_flush_e", 32'(fe), 0);
    chk("rst_stall_count", sc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x3
    ins(1, 2, 5); tick();
    ins(5, 3, 6); tick();
    nop();
    chk("exex_a", 32'(fa), 32'd2);
    chk("exex_b", 32'(fb), 32'd0);
    chk("exex_nostall", 32'(sd), 0);
    tick();

    // addi x7 ; nop ; or x8,x7,x7
    drive(1, 1, 0, 0, 7, 1, 0, 0, 0); tick();
    nop(); tick();
    ins(7, 7, 8); tick();
    nop();
    chk("wb_a", 32'(fa), 32'd1);
    chk("wb_b", 32'(fb), 32'd1);
    tick();

    // addi x7 ; addi x7 ; or x8,x7,x7 : MEM wins
    drive(1, 1, 0, 0, 7, 1, 0, 0, 0); tick();
    drive(2, 1, 0, 0, 7, 1, 0, 0, 0); tick();
    ins(7, 7, 8); tick();
    nop();
    chk("memprio_a", 32'(fa), 32'd2);
    chk("memprio_b", 32'(fb), 32'd2);
    tick();
    nop(); tick(); nop(); tick();

    // lw x9,0(x1) ; add x10,x9,x0
    sc_before = m_sc;
    drive(1, 1, 0, 0, 9, 1, 1, 0, 0); tick();
    ins(9, 0, 10);
    chk("lu_stall_f", 32'(sf), 1);
    chk("lu_flush_e", 32'(fe), 1);
    tick();
    ins(9, 0, 10);
    chk("lu_one_cycle", 32'(sd), 0);
    tick();
    nop();
    chk("lu_fwd_a", 32'(fa), 32'd1);
    chk("lu_fwd_b", 32'(fb), 32'd0);
    chk("lu_count", sc, 32'(sc_before + 1));
    tick();

    // jal x1,L ; target reads x1 while jal in MEM
    drive(0, 0, 0, 0, 1, 1, 0, 1, 0); tick();
    ins(1, 0, 3); tick();
    nop();
    chk("jal_fwd_a", 32'(fa), 32'd3);
    tick();

    // branch taken in EX for one cycle
    sc_before = m_fc;
    ins(2, 3, 4);
    tick();
    drive(2, 1, 3, 1, 4, 1, 0, 0, 1);
    chk("br_flush_d", 32'(fd), 1);
    chk("br_flush_e", 32'(fe), 1);
    chk("br_stall", 32'(sd), 0);
    tick();
    nop();
    chk("br_count", fc, 32'(sc_before + 1));
    tick();

    // write x0 then read x0
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
    ins(0, 0, 5); tick();
    nop();
    chk("x0_a", 32'(fa), 0);
    chk("x0_b", 32'(fb), 0);
    tick();

    // load-use colliding with a taken branch: flush wins
    drive(1, 1, 0, 0, 9, 1, 1, 0, 0); tick();
    drive(9, 1, 0, 0, 10, 1, 0, 0, 1);
    chk("collide_stall", 32'(sd), 0);
    chk("collide_flush_d", 32'(fd), 1);
    tick();

    // reset dropped mid-stall
    drive(1, 1, 0, 0, 9, 1, 1, 0, 0); tick();
    ins(9, 0, 10);
    chk("pre_rst_stall", 32'(sd), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(sd), 0);
    chk("async_rst_flush_e", 32'(fe), 0);
    chk("async_rst_fwd_a", 32'(fa), 0);
    chk("async_rst_scount", sc, 0);
    chk("async_rst_fcount", fc, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 20 load-use stalls: 4-bit counter pins at 15
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 9, 1, 1, 0, 0); tick();
      drive(0, 0, 9, 1, 10, 1, 0, 0, 0); tick();
    end
    nop();
    chk("sat_count4", 32'(sc4), 32'd15);
    chk("sat_count32", sc, 32'd20);
    tick();

    // random traffic over a small register set to provoke hits
    for (int i = 0; i < 400; i++) begin
      bit ld, jp;
      ld = ($urandom_range(0, 2) == 0);
      jp = !ld && ($urandom_range(0, 5) == 0);
      drive(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            ld, jp, ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
